// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//  - state_e       : fetch FSM state encoding
//  - RESET_VECTOR  : default PC after reset
//  - OP/FUNCT/RD   : bit positions of the decoder fields inside Instr
//  - word_align()  : clears the byte-offset bits of an address
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_VALID,
    S_FAULT
  } state_e;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  localparam int OP_HI    = 27;
  localparam int OP_LO    = 26;
  localparam int FUNCT_HI = 25;
  localparam int FUNCT_LO = 20;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 12;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_wdog.sv
// fetch_wdog: counts cycles an imem request has gone unacknowledged.
//  clk, reset : clock, async active-high reset
//  clr        : return the count to zero (takes priority over en)
//  en         : advance the count by one
//  expired    : count has reached MAX_WAIT-1
module fetch_wdog
  import fetch_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int WAIT_W   = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [WAIT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      count <= '0;
    else if (clr)   count <= '0;
    else if (en)    count <= count + 1'b1;
  end

  assign expired = (count == WAIT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: holds the PC, fetches one instruction at a time from imem over
// a req/ack handshake and presents it to the decoder until consumed.
//  clk, reset    : clock, async active-high reset
//  imem_req/addr : fetch request and word address (= PC)
//  imem_ack/rdata: memory response; rdata captured in the ack cycle
//  Instr         : held instruction; InstrValid while awaiting consumption
//  dec_ready     : decoder consumes Instr this cycle
//  PCSrc/BranchTarget : redirect applied when the held instr is consumed
//  InstrPC/PCPlus8: address of held instruction and that address + 8
//  fetch_fault   : sticky, imem failed to ack within MAX_WAIT cycles
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = fetch_pkg::RESET_VECTOR,
  parameter int          MAX_WAIT     = 16,
  parameter int          WAIT_W       = 5
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic        InstrValid,
  input  logic        dec_ready,
  input  logic        PCSrc,
  input  logic [31:0] BranchTarget,
  output logic [31:0] InstrPC,
  output logic [31:0] PCPlus8,
  output logic        fetch_fault
);

  state_e      state, state_nxt;
  logic [31:0] pc;
  logic        expired;
  logic        in_fetch;
  logic        take;     // memory returned the word we asked for
  logic        consume;  // decoder takes the held instruction

  assign in_fetch = (state == S_FETCH);
  assign take     = in_fetch & imem_ack;
  assign consume  = (state == S_VALID) & dec_ready;

  fetch_wdog #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (~in_fetch | imem_ack),
    .en      (in_fetch & ~imem_ack),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // An ack in the timeout cycle still wins: the word arrived in time.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_FETCH;
      S_FETCH: begin
        if (imem_ack)     state_nxt = S_VALID;
        else if (expired) state_nxt = S_FAULT;
      end
      S_VALID: if (dec_ready) state_nxt = S_FETCH;
      S_FAULT: state_nxt = S_FAULT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // PC already points past the held instruction, so only a redirect moves it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_VECTOR;
      Instr       <= '0;
      InstrPC     <= RESET_VECTOR;
      InstrValid  <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      InstrValid <= (state_nxt == S_VALID);
      if (take) begin
        Instr   <= imem_rdata;
        InstrPC <= pc;
        pc      <= pc + 32'd4;
      end else if (consume && PCSrc) begin
        pc <= word_align(BranchTarget);
      end
      if (in_fetch && !imem_ack && expired) fetch_fault <= 1'b1;
    end
  end

  assign imem_req  = in_fetch;
  assign imem_addr = pc;
  assign PCPlus8   = InstrPC + 32'd8;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed + random stimulus; a transaction-level model of
// the fetch stage predicts the outputs after every clock and a monitor on the
// falling edge pops and compares them.
module tb_fetch_stage;

  localparam int MAX_WAIT = 16;
  localparam int WAIT_W   = 5;
  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] Instr;
  logic        InstrValid;
  logic        dec_ready;
  logic        PCSrc;
  logic [31:0] BranchTarget;
  logic [31:0] InstrPC;
  logic [31:0] PCPlus8;
  logic        fetch_fault;

  fetch_stage #(.RESET_VECTOR(RV), .MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .Instr(Instr),
    .InstrValid(InstrValid), .dec_ready(dec_ready), .PCSrc(PCSrc),
    .BranchTarget(BranchTarget), .InstrPC(InstrPC), .PCPlus8(PCPlus8),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: what the stage is doing, at the level of "waiting for
  // memory", "holding an instruction", "dead", or "just out of reset".
  logic        m_starting, m_waiting, m_holding, m_dead;
  logic [31:0] m_pc, m_instr, m_ipc;
  int          m_misses;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic void model_reset();
    m_starting = 1'b1; m_waiting = 1'b0; m_holding = 1'b0; m_dead = 1'b0;
    m_pc = RV; m_instr = '0; m_ipc = RV; m_misses = 0;
  endfunction

  function automatic void model_step();
    if (reset) begin
      model_reset();
    end else if (m_dead) begin
      // nothing ever leaves the fault without reset
    end else if (m_starting) begin
      m_starting = 1'b0; m_waiting = 1'b1;
    end else if (m_waiting) begin
      if (imem_ack) begin
        m_instr = imem_rdata; m_ipc = m_pc; m_pc = m_pc + 4;
        m_misses = 0; m_waiting = 1'b0; m_holding = 1'b1;
      end else begin
        m_misses++;
        if (m_misses == MAX_WAIT) begin m_waiting = 1'b0; m_dead = 1'b1; end
      end
    end else if (m_holding && dec_ready) begin
      if (PCSrc) m_pc = BranchTarget & 32'hFFFF_FFFC;
      m_holding = 1'b0; m_waiting = 1'b1;
    end
  endfunction

  function automatic exp_t cur_exp();
    exp_t e;
    e.req = m_waiting; e.addr = m_pc; e.valid = m_holding;
    e.instr = m_instr; e.ipc = m_ipc; e.fault = m_dead;
    return e;
  endfunction

  // Monitor: outputs settled since the last rising edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("imem_req", {31'd0, imem_req}, {31'd0, e.req});
      if (e.req) chk("imem_addr", imem_addr, e.addr);
      chk("InstrValid", {31'd0, InstrValid}, {31'd0, e.valid});
      chk("Instr", Instr, e.instr);
      chk("InstrPC", InstrPC, e.ipc);
      chk("PCPlus8", PCPlus8, e.ipc + 32'd8);
      chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, e.fault});
    end
  end

  // One clock: inputs change just after the falling edge, model advances at
  // the rising edge and its prediction is queued for the monitor.
  task automatic cyc(input logic rs, input logic a, input logic r, input logic s,
                     input logic [31:0] t, input logic [31:0] d);
    @(negedge clk);
    #1;
    reset = rs; imem_ack = a; dec_ready = r; PCSrc = s; BranchTarget = t; imem_rdata = d;
    @(posedge clk);
    model_step();
    exp_q.push_back(cur_exp());
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); // leaves idle
  endtask

  // Run ack=1, dec_ready=1 until the model holds the instruction at 'pc'.
  task automatic run_to_hold(input logic [31:0] pc);
    int n = 0;
    while (!(m_holding && m_ipc == pc) && n < 200) begin
      cyc(1'b0, 1'b1, m_holding, 1'b0, 32'h0, $urandom);
      n++;
    end
    if (n >= 200) begin
      errors++;
      $display("FAIL run_to_hold: timeout reaching pc %h", pc);
    end
  endtask

  initial begin
    reset = 1'b1; imem_ack = 1'b0; dec_ready = 1'b0; PCSrc = 1'b0;
    BranchTarget = '0; imem_rdata = '0;
    model_reset();

    // 1: streaming with ack tied high
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, $urandom, $urandom);

    // 2: stall with a known word held
    do_reset();
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'hE082_0003);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, $urandom, $urandom);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h1234_5678);

    // 3: branch from 0x10 to 0x103 -> 0x100
    do_reset();
    run_to_hold(32'h10);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0103, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'hCAFE_0001);

    // 4: timeout, ack after fault ignored, reset clears
    do_reset();
    for (int i = 0; i < MAX_WAIT; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, $urandom);
    #1 chk("fault_sticky", {31'd0, fetch_fault}, 32'd1);
    do_reset();
    #1 chk("fault_cleared", {31'd0, fetch_fault}, 32'd0);

    // 5: reset during a request with ack the same cycle
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, $urandom);

    // 6: wrap from 0xFFFF_FFFC, then ack on the last allowed wait
    run_to_hold(32'h8);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0BAD_F00D);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < MAX_WAIT - 1; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h5555_AAAA);
    #1 chk("wrap_no_fault", {31'd0, fetch_fault}, 32'd0);
    chk("wrap_instr_pc", InstrPC, 32'h0);

    // Random traffic with occasional resets and redirects
    for (int i = 0; i < 400; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : ($urandom & 32'h0000_0FFF);
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
          $urandom_range(0, 1), $urandom_range(0, 1), tgt, $urandom);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
